// File: rtl/axis_tx_framer.sv
// AXI-Stream transmit framer: turns a byte-length descriptor plus payload words into one
// AXI-Stream frame with tkeep/tlast, a registered output stage and a transmitted-frame counter.
module axis_tx_framer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [LEN_WIDTH-1:0]  desc_len,
  input  logic                  pld_valid,
  output logic                  pld_ready,
  input  logic [DATA_WIDTH-1:0] pld_data,
  output logic                  tvalid,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic [DATA_WIDTH/8-1:0] tkeep,
  output logic                  tlast,
  input  logic                  tready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic                  zero_len_err
);

  localparam int unsigned KW = DATA_WIDTH / 8;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StStream = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;
  logic [KW-1:0]         keep_last_q, keep_last_d;
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KW-1:0]         tkeep_q, tkeep_d;
  logic                  tlast_q, tlast_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  zle_q, zle_d;

  logic                  desc_fire, pld_fire, beat_done, last_beat;
  logic [LEN_WIDTH-1:0]  len_rem, n_beats;
  logic [KW-1:0]         len_keep;

  // Ready outputs are forced low while reset is asserted.
  assign desc_ready = rst_n && (state_q == StIdle);
  assign pld_ready  = rst_n && (state_q == StStream) && (!tvalid_q || tready);

  assign desc_fire = desc_valid && desc_ready;
  assign pld_fire  = pld_valid && pld_ready;
  assign beat_done = tvalid_q && tready;
  assign last_beat = (beats_q == LEN_WIDTH'(1));

  assign len_rem = desc_len % LEN_WIDTH'(KW);
  assign n_beats = desc_len / LEN_WIDTH'(KW) + LEN_WIDTH'(len_rem != '0);

  always_comb begin
    len_keep = '1;
    if (len_rem != '0) begin
      for (int i = 0; i < KW; i++) begin
        len_keep[i] = (LEN_WIDTH'(i) < len_rem);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    keep_last_d = keep_last_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    zle_d       = 1'b0;
    cnt_d       = cnt_q + CNT_WIDTH'(beat_done && tlast_q);

    case (state_q)
      StIdle: begin
        if (desc_fire) begin
          if (desc_len == '0) begin
            zle_d = 1'b1;
          end else begin
            beats_d     = n_beats;
            keep_last_d = len_keep;
            state_d     = StStream;
          end
        end
      end
      StStream: begin
        if (pld_fire) begin
          beats_d = beats_q - LEN_WIDTH'(1);
          if (last_beat) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new load overrides the drain so back-to-back beats have no bubble.
    if (pld_fire) begin
      tvalid_d = 1'b1;
      tdata_d  = pld_data;
      tlast_d  = last_beat;
      tkeep_d  = last_beat ? keep_last_q : '1;
    end else if (beat_done) begin
      tvalid_d = 1'b0;
      tdata_d  = '0;
      tkeep_d  = '0;
      tlast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      beats_q     <= '0;
      keep_last_q <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      cnt_q       <= '0;
      zle_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      keep_last_q <= keep_last_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      cnt_q       <= cnt_d;
      zle_q       <= zle_d;
    end
  end

  assign tvalid       = tvalid_q;
  assign tdata        = tdata_q;
  assign tkeep        = tkeep_q;
  assign tlast        = tlast_q;
  assign busy         = (state_q != StIdle) || tvalid_q;
  assign frame_cnt    = cnt_q;
  assign zero_len_err = zle_q;

endmodule
